mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
// - Shares one single-port 32-bit word memory between the instruction-fetch requester (IF)
//   and the load/store requester (D). Replaces clock-level muxing with a registered
//   arbiter and sequencer.
// - Sits between the fetch/MEM stages and the memory array. Handles byte/half/word sizes,
//   sign extension and word-boundary-crossing splits.
// PARAMETERS
// - AW          10    word-address width of memory backend
// - DATA_BASE   200   byte offset added to d_addr (data region follows the program region)
// - FAIR_LIMIT  4     consecutive D grants allowed while if_req pending before IF is forced
// PORTS
// - clk         in   1   rising-edge clock
// - rst         in   1   asynchronous reset, active-low (0 = reset)
// - if_req      in   1   fetch request, held until if_gnt
// - if_addr     in   32  fetch byte address, word-aligned
// - if_gnt      out  1   fetch accepted (1-cycle pulse)
// - if_rvalid   out  1   if_rdata valid (1-cycle pulse)
// - if_rdata    out  32  fetched word
// - d_req       in   1   data request, held with all d_* stable until d_gnt
// - d_we        in   1   1 = store, 0 = load
// - d_size      in   3   3'b001 byte, 3'b010 half, 3'b100 word; other codes = word
// - d_unsigned  in   1   zero-extend loads when 1, sign-extend when 0
// - d_addr      in   32  data byte address, any alignment
// - d_wdata     in   32  store data, little-endian, LSBs used for byte/half
// - d_gnt       out  1   data accepted (1-cycle pulse, on first beat)
// - d_rvalid    out  1   load data valid (1-cycle pulse); no pulse for stores
// - d_rdata     out  32  extended load result
// - mem_en      out  1   backend access strobe
// - mem_we      out  1   backend write
// - mem_addr    out  AW  backend word address
// - mem_be      out  4   backend byte enables (bit i = byte lane i)
// - mem_wdata   out  32  backend write data, lane-aligned
// - mem_rdata   in   32  backend read data, valid cycle after mem_en & ~mem_we
// BEHAVIOUR
// - Reset: all outputs 0, FSM IDLE, fairness counter 0, split registers cleared.
// - Arbitration in IDLE: D beats IF unless fair_cnt == FAIR_LIMIT and if_req is high.
//   fair_cnt increments on each D grant while if_req high, clears on any IF grant.
// - Effective data address ea = d_addr + DATA_BASE. Word = ea[AW+1:2], lane = ea[1:0].
// - Split when lane + bytes(d_size) > 4. Otherwise the access is single-beat.
// - Single-beat access: gnt and mem_en in the same cycle as the IDLE decision.
//   Loads give rvalid exactly 1 cycle later. Stores give no response.
// - Split access: beat 1 is issued with the gnt and covers lanes lane..3 of word W.
//   Beat 2 is issued the next cycle (port locked, no gnt to anyone) and covers lanes
//   0..n of W+1. A split load gives d_rvalid 1 cycle after beat 2, with bytes merged in order.
// - FSM states and transitions:
//   - IDLE -> SPLIT2 (split D accepted)
//   - IDLE -> RESP (single-beat load accepted)
//   - SPLIT2 -> RESP (load) or IDLE (store)
//   - RESP -> IDLE
//   - RESP may also accept a new request in the same cycle (back-to-back throughput
//     1 access/cycle).
// - Store lanes: mem_wdata = d_wdata shifted left by 8*lane (mod 32); mem_be is set for
//   each written lane. Beat 2 carries the remaining upper bytes at lanes 0..
// - Load extension: byte uses bit 7 and half uses bit 15 of the merged data, unless
//   d_unsigned is high.
// - IF accesses are always single-beat word reads with mem_be = 4'hF. mem_en = 0 when idle.
// - Both requesters asserting in the same cycle: exactly one gnt; the loser's req stays pending.
// - Address wrap: W+1 wraps modulo 2^AW.
// - Reset mid-split: the access is abandoned, no rvalid, beat 2 is never issued.
// STRUCTURE
// - Shared package mem_pkg: SIZE_B/SIZE_H/SIZE_W constants, FSM state enum, and the
//   bytes-of-size function.
// - One sub-module, load_align_ext: combinational lane shift/merge plus sign/zero
//   extension. Reused by the data-memory read path.
// TESTING
// - Aligned word store 0xDEADBEEF at d_addr 0: mem_addr 50, mem_be F. A following load
//   gives d_rvalid 1 cycle after d_gnt with d_rdata 0xDEADBEEF.
// - Load byte, lane byte 0x80, at d_addr 1: d_unsigned=0 -> 0xFFFFFF80;
//   d_unsigned=1 -> 0x00000080.
// - Word store 0x11223344 at d_addr 2: beat 1 is be=1100 at W=50, beat 2 is be=0011 at
//   W=51. A load from the same address returns 0x11223344, 2 cycles after d_gnt.
// - if_req and d_req held high together for 6 cycles with FAIR_LIMIT=4: 4 d_gnt pulses,
//   then 1 if_gnt, then d_gnt resumes.
// - Assert rst low in SPLIT2: outputs go 0 immediately, no beat 2, no d_rvalid.
//   After release the FSM is IDLE.
// - IF-only stream at addrs 0,4,8: if_gnt every cycle, if_rvalid 1 cycle later,
//   mem_be = F, mem_we = 0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the memory port arbiter: access-size codes, FSM states
// and the byte count of each size code.
package mem_pkg;

  localparam logic [2:0] SIZE_B = 3'b001;
  localparam logic [2:0] SIZE_H = 3'b010;
  localparam logic [2:0] SIZE_W = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SPLIT2 = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  // Unknown size codes are treated as full words.
  function automatic logic [2:0] size_bytes(input logic [2:0] size);
    case (size)
      SIZE_B:  return 3'd1;
      SIZE_H:  return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/load_align_ext.sv
// Combinational load path: shifts the addressed bytes of one or two memory words
// down to bit 0 and applies sign or zero extension for byte/half loads.
module load_align_ext
  import mem_pkg::*;
(
  input  logic [31:0] lo_word,
  input  logic [31:0] hi_word,
  input  logic [1:0]  lane,
  input  logic [2:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] data
);

  logic [63:0] merged;
  logic [31:0] raw;
  logic        unused_hi;

  // hi_word supplies the bytes that spill past lane 3 on a split access
  assign merged    = {hi_word, lo_word} >> {lane, 3'b000};
  assign raw       = merged[31:0];
  assign unused_hi = ^merged[63:32];

  always_comb begin
    data = raw;
    case (size_bytes(size))
      3'd1:    data = {{24{~is_unsigned & raw[7]}}, raw[7:0]};
      3'd2:    data = {{16{~is_unsigned & raw[15]}}, raw[15:0]};
      default: data = raw;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Registered arbiter/sequencer sharing one single-port word memory between the
// fetch port and the load/store port, with split handling for unaligned data.
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int AW         = 10,
  parameter int DATA_BASE  = 200,
  parameter int FAIR_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [31:0]   if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [31:0]   if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [2:0]    d_size,
  input  logic          d_unsigned,
  input  logic [31:0]   d_addr,
  input  logic [31:0]   d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [31:0]   d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [3:0]    mem_be,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  localparam int FW = $clog2(FAIR_LIMIT + 1);

  state_t          state_reg, state_next;
  logic [FW-1:0]   fair_cnt_reg;
  logic [AW-1:0]   split_addr_reg;
  logic [3:0]      split_be_reg;
  logic            split_we_reg;
  logic [31:0]     split_wdata_reg;
  logic [1:0]      resp_lane_reg;
  logic [2:0]      resp_size_reg;
  logic            resp_uns_reg;
  logic            resp_split_reg;
  logic [31:0]     lo_word_reg;
  logic            if_rvalid_reg;
  logic            d_rvalid_reg;

  logic [31:0]     ea;
  logic [AW-1:0]   d_word;
  logic [1:0]      d_lane;
  logic [7:0]      d_mask8;
  logic [7:0]      d_be8;
  logic            d_split;
  logic [63:0]     d_wdup;
  logic [31:0]     d_wrot;
  logic            port_free;
  logic            grant_d;
  logic            grant_if;
  logic [31:0]     align_out;
  logic            unused_bits;

  assign ea      = d_addr + 32'(DATA_BASE);
  assign d_word  = ea[AW+1:2];
  assign d_lane  = ea[1:0];
  assign d_mask8 = (8'd1 << size_bytes(d_size)) - 8'd1;
  assign d_be8   = d_mask8 << d_lane;
  assign d_split = |d_be8[7:4];
  // Rotating the store word puts the low bytes at lanes lane..3 of beat 1 and the
  // spilled upper bytes at lanes 0.. of beat 2 in a single word.
  assign d_wdup  = {d_wdata, d_wdata} << {d_lane, 3'b000};
  assign d_wrot  = d_wdup[63:32];

  assign unused_bits = ^{ea[31:AW+2], if_addr[31:AW+2], if_addr[1:0], d_wdup[31:0]};

  assign port_free = rst && (state_reg != ST_SPLIT2);
  assign grant_d   = port_free && d_req &&
                     !(if_req && (fair_cnt_reg == FW'(FAIR_LIMIT)));
  assign grant_if  = port_free && if_req && !grant_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= ST_IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_SPLIT2: state_next = split_we_reg ? ST_IDLE : ST_RESP;
      default: begin
        if (grant_d && d_split)                     state_next = ST_SPLIT2;
        else if ((grant_d && !d_we) || grant_if)    state_next = ST_RESP;
        else                                        state_next = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_be    = 4'h0;
    mem_wdata = 32'h0;
    if (rst && (state_reg == ST_SPLIT2)) begin
      mem_en    = 1'b1;
      mem_we    = split_we_reg;
      mem_addr  = split_addr_reg;
      mem_be    = split_be_reg;
      mem_wdata = split_wdata_reg;
    end else if (grant_d) begin
      d_gnt     = 1'b1;
      mem_en    = 1'b1;
      mem_we    = d_we;
      mem_addr  = d_word;
      mem_be    = d_be8[3:0];
      mem_wdata = d_we ? d_wrot : 32'h0;
    end else if (grant_if) begin
      if_gnt    = 1'b1;
      mem_en    = 1'b1;
      mem_addr  = if_addr[AW+1:2];
      mem_be    = 4'hF;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fair_cnt_reg    <= '0;
      split_addr_reg  <= '0;
      split_be_reg    <= 4'h0;
      split_we_reg    <= 1'b0;
      split_wdata_reg <= 32'h0;
      resp_lane_reg   <= 2'd0;
      resp_size_reg   <= 3'd0;
      resp_uns_reg    <= 1'b0;
      resp_split_reg  <= 1'b0;
      lo_word_reg     <= 32'h0;
      if_rvalid_reg   <= 1'b0;
      d_rvalid_reg    <= 1'b0;
    end else begin
      if (grant_if)                fair_cnt_reg <= '0;
      else if (grant_d && if_req)  fair_cnt_reg <= fair_cnt_reg + FW'(1);
      if (grant_d && d_split) begin
        split_addr_reg  <= d_word + AW'(1);
        split_be_reg    <= d_be8[7:4];
        split_we_reg    <= d_we;
        split_wdata_reg <= d_we ? d_wrot : 32'h0;
      end
      if (grant_d && !d_we) begin
        resp_lane_reg  <= d_lane;
        resp_size_reg  <= d_size;
        resp_uns_reg   <= d_unsigned;
        resp_split_reg <= d_split;
      end
      // Beat-1 read data arrives while beat 2 is on the port
      if (state_reg == ST_SPLIT2) lo_word_reg <= mem_rdata;
      if_rvalid_reg <= grant_if;
      d_rvalid_reg  <= (grant_d && !d_we && !d_split) ||
                       ((state_reg == ST_SPLIT2) && !split_we_reg);
    end
  end

  load_align_ext u_align (
    .lo_word     (resp_split_reg ? lo_word_reg : mem_rdata),
    .hi_word     (resp_split_reg ? mem_rdata : 32'h0),
    .lane        (resp_lane_reg),
    .size        (resp_size_reg),
    .is_unsigned (resp_uns_reg),
    .data        (align_out)
  );

  assign if_rvalid = if_rvalid_reg;
  assign if_rdata  = if_rvalid_reg ? mem_rdata : 32'h0;
  assign d_rvalid  = d_rvalid_reg;
  assign d_rdata   = d_rvalid_reg ? align_out : 32'h0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: byte-level reference memory plus per-cycle scoreboard,
// with directed scenarios pinned by hand-computed values.
module tb_mem_port_arbiter;

  typedef struct packed {
    logic [9:0]  addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
  } beat_t;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [2:0]  d_size;
  logic        d_unsigned;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [31:0] bmem [0:1023];
  logic [7:0]  gold [0:4095];
  beat_t       exp_beat [int];
  logic [31:0] exp_drv  [int];
  logic [31:0] exp_irv  [int];
  beat_t       eb;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_unsigned(d_unsigned),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Backend memory: byte-enabled writes, one-cycle registered reads
  initial begin
    for (int i = 0; i < 1024; i++) bmem[i] = 32'h0;
    for (int i = 0; i < 4096; i++) gold[i] = 8'h0;
    mem_rdata = 32'h0;
  end

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int i = 0; i < 4; i++)
          if (mem_be[i]) bmem[mem_addr][i*8 +: 8] <= mem_wdata[i*8 +: 8];
      end else begin
        mem_rdata <= bmem[mem_addr];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s actual=%08h required=%08h", name, act, exp);
    else n_pass++;
  endtask

  // Reference for one granted data access, walking its bytes one at a time
  task automatic model_d(input int c);
    logic [31:0] ea, val;
    logic [9:0]  w0;
    beat_t       b [2];
    int          n, nb, ba, k;
    ea  = d_addr + 32'd200;
    n   = (d_size == 3'b001) ? 1 : (d_size == 3'b010) ? 2 : 4;
    w0  = ea[11:2];
    b[0] = '0;
    b[1] = '0;
    nb  = 1;
    val = 32'h0;
    for (int i = 0; i < n; i++) begin
      ba = int'((ea + 32'(i)) & 32'hFFF);
      k  = ((ba >> 2) == int'(w0)) ? 0 : 1;
      if (k == 1) nb = 2;
      b[k].addr = 10'(ba >> 2);
      b[k].be[ba % 4] = 1'b1;
      b[k].we = d_we;
      if (d_we) begin
        b[k].wdata[(ba % 4)*8 +: 8] = d_wdata[i*8 +: 8];
        gold[ba] = d_wdata[i*8 +: 8];
      end else begin
        val[i*8 +: 8] = gold[ba];
      end
    end
    if (!d_unsigned && n == 1 && val[7])  val[31:8]  = 24'hFFFFFF;
    if (!d_unsigned && n == 2 && val[15]) val[31:16] = 16'hFFFF;
    chk("port_lock", 32'(exp_beat.exists(c)), 32'd0);
    chk("d_gnt_req", {31'd0, d_req}, 32'd1);
    exp_beat[c] = b[0];
    if (nb == 2) exp_beat[c+1] = b[1];
    if (!d_we) exp_drv[c+nb] = val;
    $display("txn cyc=%0d D we=%0d size=%0d uns=%0d addr=%0d wdata=%08h beats=%0d",
             c, d_we, d_size, d_unsigned, d_addr, d_wdata, nb);
  endtask

  task automatic model_if(input int c);
    int w;
    beat_t b;
    w = int'(if_addr[11:2]);
    b.addr = 10'(w);
    b.be = 4'hF;
    b.we = 1'b0;
    b.wdata = 32'h0;
    chk("port_lock_if", 32'(exp_beat.exists(c)), 32'd0);
    exp_beat[c] = b;
    exp_irv[c+1] = {gold[4*w+3], gold[4*w+2], gold[4*w+1], gold[4*w]};
    $display("txn cyc=%0d IF addr=%0d", c, if_addr);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_ctl", {26'd0, mem_en, mem_we, if_gnt, d_gnt, if_rvalid, d_rvalid}, 32'd0);
      chk("rst_bus", {22'd0, mem_addr} | {28'd0, mem_be} | mem_wdata | if_rdata | d_rdata, 32'd0);
      exp_beat.delete();
      exp_drv.delete();
      exp_irv.delete();
    end else begin
      chk("one_gnt", {31'd0, d_gnt & if_gnt}, 32'd0);
      if (d_gnt) model_d(cyc);
      if (if_gnt) model_if(cyc);
      if (exp_beat.exists(cyc)) begin
        eb = exp_beat[cyc];
        chk("mem_en", {31'd0, mem_en}, 32'd1);
        chk("mem_we", {31'd0, mem_we}, {31'd0, eb.we});
        chk("mem_addr", {22'd0, mem_addr}, {22'd0, eb.addr});
        chk("mem_be", {28'd0, mem_be}, {28'd0, eb.be});
        if (eb.we)
          chk("mem_wdata", mem_wdata & {{8{eb.be[3]}}, {8{eb.be[2]}}, {8{eb.be[1]}}, {8{eb.be[0]}}},
              eb.wdata);
        exp_beat.delete(cyc);
      end else begin
        chk("mem_idle", {31'd0, mem_en}, 32'd0);
      end
      if (exp_drv.exists(cyc)) begin
        chk("d_rvalid", {31'd0, d_rvalid}, 32'd1);
        chk("d_rdata", d_rdata, exp_drv[cyc]);
        exp_drv.delete(cyc);
      end else begin
        chk("d_rvalid_idle", {31'd0, d_rvalid}, 32'd0);
      end
      if (exp_irv.exists(cyc)) begin
        chk("if_rvalid", {31'd0, if_rvalid}, 32'd1);
        chk("if_rdata", if_rdata, exp_irv[cyc]);
        exp_irv.delete(cyc);
      end else begin
        chk("if_rvalid_idle", {31'd0, if_rvalid}, 32'd0);
      end
    end
  end

  // Called just after a rising edge; returns just after a rising edge.
  task automatic d_access(input logic we, input logic [2:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd, input bit wait_resp,
                          output logic [31:0] rd, output int lat,
                          output logic [9:0] baddr, output logic [3:0] bbe);
    int gc;
    bit got, seen;
    d_req = 1'b1; d_we = we; d_size = sz; d_unsigned = uns; d_addr = addr; d_wdata = wd;
    got = 0; gc = 0; baddr = '0; bbe = '0; rd = '0; lat = -1;
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge clk);
      if (d_gnt) begin
        got = 1; gc = cyc; baddr = mem_addr; bbe = mem_be;
      end else begin
        @(posedge clk); #1;
      end
    end
    chk("d_gnt_wait", {31'd0, got}, 32'd1);
    @(posedge clk); #1;
    d_req = 1'b0;
    if (wait_resp && got) begin
      seen = 0;
      for (int k = 0; k < 6 && !seen; k++) begin
        @(negedge clk);
        if (d_rvalid) begin
          seen = 1; rd = d_rdata; lat = cyc - gc;
        end
      end
      chk("d_rvalid_wait", {31'd0, seen}, 32'd1);
      @(posedge clk); #1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    int          lat;
    logic [9:0]  ba;
    logic [3:0]  bb;
    logic [5:0]  dg, ig;
    logic [2:0]  sg;
    logic [31:0] first_if;

    rst = 1'b0; if_req = 1'b0; if_addr = 32'h0;
    d_req = 1'b0; d_we = 1'b0; d_size = 3'b100; d_unsigned = 1'b0;
    d_addr = 32'h0; d_wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {26'd0, mem_en, mem_we, if_gnt, d_gnt, if_rvalid, d_rvalid}, 32'd0);
    rst = 1'b1;
    idle(1);

    // Aligned word store and load-back
    d_access(1'b1, 3'b100, 1'b0, 32'd0, 32'hDEADBEEF, 1'b0, rd, lat, ba, bb);
    chk("st_word_addr", {22'd0, ba}, 32'd50);
    chk("st_word_be", {28'd0, bb}, 32'h0000000F);
    d_access(1'b0, 3'b100, 1'b0, 32'd0, 32'h0, 1'b1, rd, lat, ba, bb);
    chk("ld_word_data", rd, 32'hDEADBEEF);
    chk("ld_word_lat", 32'(lat), 32'd1);

    // Byte 0x80 at lane 1, signed and unsigned
    d_access(1'b1, 3'b001, 1'b0, 32'd1, 32'h00000080, 1'b0, rd, lat, ba, bb);
    chk("st_byte_be", {28'd0, bb}, 32'h00000002);
    d_access(1'b0, 3'b001, 1'b0, 32'd1, 32'h0, 1'b1, rd, lat, ba, bb);
    chk("ld_byte_signed", rd, 32'hFFFFFF80);
    d_access(1'b0, 3'b001, 1'b1, 32'd1, 32'h0, 1'b1, rd, lat, ba, bb);
    chk("ld_byte_unsigned", rd, 32'h00000080);

    // Word store crossing into the next word
    d_access(1'b1, 3'b100, 1'b0, 32'd2, 32'h11223344, 1'b0, rd, lat, ba, bb);
    chk("split_b1_addr", {22'd0, ba}, 32'd50);
    chk("split_b1_be", {28'd0, bb}, 32'h0000000C);
    @(negedge clk);
    chk("split_b2_addr", {22'd0, mem_addr}, 32'd51);
    chk("split_b2_be", {28'd0, mem_be}, 32'h00000003);
    @(posedge clk); #1;
    d_access(1'b0, 3'b100, 1'b0, 32'd2, 32'h0, 1'b1, rd, lat, ba, bb);
    chk("split_ld_data", rd, 32'h11223344);
    chk("split_ld_lat", 32'(lat), 32'd2);
    d_access(1'b0, 3'b010, 1'b0, 32'd3, 32'h0, 1'b1, rd, lat, ba, bb);
    chk("split_half", rd, 32'h00002233);
    d_access(1'b0, 3'b000, 1'b0, 32'd0, 32'h0, 1'b1, rd, lat, ba, bb);
    chk("odd_size_word", rd, 32'h334480EF);
    idle(2);

    // Both requesters held for six cycles
    d_req = 1'b1; d_we = 1'b0; d_size = 3'b100; d_unsigned = 1'b0; d_addr = 32'd0;
    if_req = 1'b1; if_addr = 32'd0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      dg[5-k] = d_gnt;
      ig[5-k] = if_gnt;
      @(posedge clk); #1;
    end
    d_req = 1'b0; if_req = 1'b0;
    chk("fair_d_pattern", {26'd0, dg}, 32'b111101);
    chk("fair_if_pattern", {26'd0, ig}, 32'b000010);
    idle(3);

    // Split word store wrapping from the top word back to word 0
    d_access(1'b1, 3'b100, 1'b0, 32'd3894, 32'hA1B2C3D4, 1'b0, rd, lat, ba, bb);
    chk("wrap_b1_addr", {22'd0, ba}, 32'd1023);
    @(negedge clk);
    chk("wrap_b2_addr", {22'd0, mem_addr}, 32'd0);
    chk("wrap_b2_be", {28'd0, mem_be}, 32'h00000003);
    @(posedge clk); #1;
    d_access(1'b0, 3'b100, 1'b0, 32'd3894, 32'h0, 1'b1, rd, lat, ba, bb);
    chk("wrap_ld_data", rd, 32'hA1B2C3D4);
    idle(2);

    // Fetch-only stream
    if_req = 1'b1; if_addr = 32'd0; first_if = 32'h0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      sg[k] = if_gnt;
      if (k == 1) first_if = if_rdata;
      @(posedge clk); #1;
      if_addr = if_addr + 32'd4;
    end
    if_req = 1'b0;
    @(negedge clk);
    chk("if_stream_gnt", {29'd0, sg}, 32'b111);
    chk("if_last_rvalid", {31'd0, if_rvalid}, 32'd1);
    chk("if_word0", first_if, 32'h0000A1B2);
    @(posedge clk); #1;
    idle(2);

    // Reset while beat 2 of a split load is due
    d_access(1'b0, 3'b100, 1'b0, 32'd2, 32'h0, 1'b0, rd, lat, ba, bb);
    rst = 1'b0;
    #1;
    chk("rst_mid_split", {26'd0, mem_en, mem_we, if_gnt, d_gnt, if_rvalid, d_rvalid}, 32'd0);
    chk("rst_mid_be", {28'd0, mem_be}, 32'd0);
    idle(2);
    rst = 1'b1;
    idle(2);
    d_access(1'b0, 3'b100, 1'b0, 32'd0, 32'h0, 1'b1, rd, lat, ba, bb);
    chk("post_rst_data", rd, 32'h334480EF);
    chk("post_rst_lat", 32'(lat), 32'd1);
    idle(3);

    chk("pending_beats", 32'(exp_beat.size()), 32'd0);
    chk("pending_d", 32'(exp_drv.size()), 32'd0);
    chk("pending_if", 32'(exp_irv.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
